irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller that drives the single-cycle `intr` input of the program-flow controller. It collects `N_SRC` external interrupt lines, latches their rising edges as pending bits, and masks them with a software-visible enable register. It selects the highest-priority pending source and issues one `intr` pulse per interrupt entry. It then blocks further entries until the core signals return-from-interrupt (`iret`). It sits beside the PC logic on the PC clock domain and exposes a small CSR window to the datapath.

## Interface
- `N_SRC`, 8, number of interrupt sources (1..16).
- `clk_pc`  in  1  PC clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `irq_src`  in  N_SRC  interrupt request lines, rising-edge sensitive.
- `iret`  in  1  one-cycle pulse from the decoder when an ISR return executes.
- `csr_we`  in  1  CSR write strobe.
- `csr_addr`  in  2  CSR select: 0 PENDING, 1 ENABLE, 2 CAUSE, 3 STATUS.
- `csr_wdata`  in  16  CSR write data.
- `csr_rdata`  out  16  CSR read data (combinational from `csr_addr`).
- `intr`  out  1  registered entry pulse to the PFC, high for exactly one cycle.
- `in_isr`  out  1  high from the `intr` cycle until `iret` is accepted.

## Operation
- Edge detection: `prev` register holds the last sample of `irq_src`. `rise = irq_src & ~prev`. Rising edges OR into `pending`.
- PENDING (addr 0): write-1-to-clear on bits [N_SRC-1:0]. If a set and a clear hit the same bit in the same cycle, the set wins. Bits above `N_SRC` read 0.
- ENABLE (addr 1): read/write, low `N_SRC` bits.
- CAUSE (addr 2): read-only. Bits [3:0] hold the index of the last taken source; other bits read 0. CSR writes are ignored.
- STATUS (addr 3): bit0 GIE is read/write. bit1 IN_ISR is read-only. Other bits read 0.
- `eligible = pending & enable`. The winner is the lowest set index.
- FSM states:
  - IDLE → ENTER when GIE=1 and `eligible` is nonzero. On this transition, latch CAUSE with the winner index and clear that pending bit. This clear overrides a simultaneous W1C write and any new rise on that bit.
  - ENTER: `intr`=1 and `in_isr`=1. Always moves to ISR on the next edge.
  - ISR: `in_isr`=1. Moves to IDLE when `iret`=1.
- `iret` is ignored in IDLE and ENTER.
- Sources that stay pending while in ENTER or ISR are serviced after return, re-arbitrated at that time.
- GIE is not modified by hardware. Software clears it if needed.

## Timing
- Reset values:
  - FSM in IDLE; `intr`=0; `in_isr`=0.
  - `pending`=0, ENABLE=0, GIE=0, CAUSE=0.
  - `prev`=0, so a line already high at reset release registers as an edge.
- Latency: rise sampled at edge k → pending set after k → FSM in ENTER after edge k+1 → PFC consumes `intr` at edge k+2.
- Minimum re-entry spacing after `iret` sampled at edge m: ENTER after edge m+1 at the earliest, because ISR→IDLE costs one edge.
- CSR writes take effect at the next edge. The FSM evaluates GIE, ENABLE and PENDING from their registered (pre-write) values.
- Reset asserted mid-ISR: the block returns immediately to the reset state. No `intr` is produced until GIE is set again.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: each `irq_src` bit passes through a 2-flop synchronizer before edge detection. Latency from the pin edge grows by 2 cycles, to k+4. Synchronizer flops reset to 0.
- Not defined: `irq_src` is used directly and must be synchronous to `clk_pc`.

## Structure
- Package `irq_pkg` contains:
  - CSR address constants `IRQ_CSR_PENDING/ENABLE/CAUSE/STATUS`;
  - STATUS bit positions;
  - state enum `irq_state_t {IRQ_IDLE, IRQ_ENTER, IRQ_ISR}`.
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder with parameter `N`, outputs `valid` and 4-bit `idx`.

## Test plan
- Reset, then set ENABLE=0x01 and GIE=1, pulse `irq_src[0]` one cycle → `intr` high exactly one cycle, 2 edges after the sampled rise; CAUSE=0; PENDING=0; `in_isr`=1.
- Rise `irq_src[5]` and `irq_src[2]` in the same cycle with ENABLE=0xFF → CAUSE=2 first. After `iret`, a second `intr` arrives with CAUSE=5.
- Rise `irq_src[3]` with ENABLE=0x00 → no `intr`, PENDING=0x08. Then write ENABLE=0x08 → `intr` occurs. Separately, writing 0x08 to PENDING before enabling clears the bit and no `intr` occurs.
- A new rise during ISR plus `iret` asserted during ENTER → `iret` ignored, no second `intr` while in ISR. A later `iret` in ISR → next `intr` two edges after that `iret`.
- Deassert `rst_n` mid-ISR with bits pending → all outputs and CSRs read their reset values. `intr` stays low after reset release until GIE is set.
- W1C and a rise on the same bit in the same cycle, with GIE=0 → the bit remains pending.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller.
// IRQ_CTRL_SYNC_EN (see irq_ctrl.sv) selects the input synchronizer.
package irq_pkg;

    localparam logic [1:0] IRQ_CSR_PENDING = 2'd0;
    localparam logic [1:0] IRQ_CSR_ENABLE  = 2'd1;
    localparam logic [1:0] IRQ_CSR_CAUSE   = 2'd2;
    localparam logic [1:0] IRQ_CSR_STATUS  = 2'd3;

    localparam int IRQ_STATUS_GIE    = 0;
    localparam int IRQ_STATUS_IN_ISR = 1;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_ENTER = 2'd1,
        IRQ_ISR   = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder; purely combinational.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = 4'd0;
        // Scan downward so the lowest set index is the last one assigned.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-latched, maskable interrupt controller: one intr pulse per entry, blocked until iret.
// Build option IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer per irq_src bit (+2 cycles latency).
import irq_pkg::*;

module irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk_pc,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             iret,
    input  logic             csr_we,
    input  logic [1:0]       csr_addr,
    input  logic [15:0]      csr_wdata,
    output logic [15:0]      csr_rdata,
    output logic             intr,
    output logic             in_isr
);

    logic [N_SRC-1:0] src_s;

`ifdef IRQ_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_pc or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    irq_state_t       state_q, state_d;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic             gie_q, gie_d;
    logic [3:0]       cause_q, cause_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] w1c_mask;
    logic             win_vld;
    logic [3:0]       win_idx;
    logic             take;
    logic             wr_pend, wr_en, wr_status;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, csr_wdata};

    assign rise      = src_s & ~prev_q;
    assign eligible  = pending_q & enable_q;
    assign wr_pend   = csr_we && (csr_addr == IRQ_CSR_PENDING);
    assign wr_en     = csr_we && (csr_addr == IRQ_CSR_ENABLE);
    assign wr_status = csr_we && (csr_addr == IRQ_CSR_STATUS);
    assign w1c_mask  = wr_pend ? csr_wdata[N_SRC-1:0] : '0;

    irq_prio_enc #(.N(N_SRC)) u_prio (
        .req   (eligible),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // Arbitration uses registered GIE/ENABLE/PENDING, never the in-flight CSR write.
    assign take = (state_q == IRQ_IDLE) && gie_q && win_vld;

    always_comb begin
        pending_d = (pending_q & ~w1c_mask) | rise;
        if (take) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (win_idx == 4'(i)) pending_d[i] = 1'b0;
            end
        end
        enable_d = wr_en ? csr_wdata[N_SRC-1:0] : enable_q;
        gie_d    = wr_status ? csr_wdata[IRQ_STATUS_GIE] : gie_q;
        cause_d  = take ? win_idx : cause_q;
    end

    always_ff @(posedge clk_pc or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            gie_q     <= 1'b0;
            cause_q   <= 4'd0;
        end else begin
            prev_q    <= src_s;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            gie_q     <= gie_d;
            cause_q   <= cause_d;
        end
    end

    always_ff @(posedge clk_pc or negedge rst_n) begin
        if (!rst_n) state_q <= IRQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IRQ_IDLE:  if (take) state_d = IRQ_ENTER;
            IRQ_ENTER: state_d = IRQ_ISR;
            IRQ_ISR:   if (iret) state_d = IRQ_IDLE;
            default:   state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        intr   = (state_q == IRQ_ENTER);
        in_isr = (state_q == IRQ_ENTER) || (state_q == IRQ_ISR);
    end

    always_comb begin
        csr_rdata = 16'd0;
        unique case (csr_addr)
            IRQ_CSR_PENDING: csr_rdata[N_SRC-1:0] = pending_q;
            IRQ_CSR_ENABLE:  csr_rdata[N_SRC-1:0] = enable_q;
            IRQ_CSR_CAUSE:   csr_rdata[3:0]       = cause_q;
            IRQ_CSR_STATUS: begin
                csr_rdata[IRQ_STATUS_GIE]    = gie_q;
                csr_rdata[IRQ_STATUS_IN_ISR] = in_isr;
            end
            default: csr_rdata = 16'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: inputs change and outputs are sampled on the falling clock edge.
module tb_irq_ctrl;
    import irq_pkg::*;

    logic        clk_pc    = 1'b0;
    logic        rst_n     = 1'b0;
    logic [7:0]  irq_src   = 8'h00;
    logic        iret      = 1'b0;
    logic        csr_we    = 1'b0;
    logic [1:0]  csr_addr  = 2'd0;
    logic [15:0] csr_wdata = 16'h0000;
    logic [15:0] csr_rdata;
    logic        intr;
    logic        in_isr;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    irq_ctrl #(.N_SRC(8)) dut (
        .clk_pc    (clk_pc),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .iret      (iret),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .intr      (intr),
        .in_isr    (in_isr)
    );

    always #5 clk_pc = ~clk_pc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_pc);
    endtask

    task automatic chk_csr(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        csr_addr = a;
        #1;
        d = csr_rdata;
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic do_iret();
        iret = 1'b1;
        tick();
        iret = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_intr", 16'(intr), 16'h0);
        chk("rst_in_isr", 16'(in_isr), 16'h0);
        chk_csr("rst_pending", IRQ_CSR_PENDING, 16'h0000);
        chk_csr("rst_enable", IRQ_CSR_ENABLE, 16'h0000);
        chk_csr("rst_cause", IRQ_CSR_CAUSE, 16'h0000);
        chk_csr("rst_status", IRQ_CSR_STATUS, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Single source, intr two edges after the sampled rise, exactly one cycle
        wr(IRQ_CSR_ENABLE, 16'h0001);
        wr(IRQ_CSR_STATUS, 16'h0001);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        chk("t1_intr_early", 16'(intr), 16'h0);
        tick();
        chk("t1_intr", 16'(intr), 16'h1);
        chk("t1_in_isr", 16'(in_isr), 16'h1);
        chk_csr("t1_cause", IRQ_CSR_CAUSE, 16'h0000);
        chk_csr("t1_pending", IRQ_CSR_PENDING, 16'h0000);
        chk_csr("t1_status", IRQ_CSR_STATUS, 16'h0003);
        tick();
        chk("t1_intr_one_cycle", 16'(intr), 16'h0);
        chk("t1_in_isr_hold", 16'(in_isr), 16'h1);
        do_iret();
        chk("t1_in_isr_clr", 16'(in_isr), 16'h0);

        // Two simultaneous rises: lowest index first, other after iret
        wr(IRQ_CSR_ENABLE, 16'h00FF);
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        chk("t2_intr_early", 16'(intr), 16'h0);
        tick();
        chk("t2_intr_a", 16'(intr), 16'h1);
        chk_csr("t2_cause_a", IRQ_CSR_CAUSE, 16'h0002);
        chk_csr("t2_pending_a", IRQ_CSR_PENDING, 16'h0020);
        tick();
        chk("t2_isr_no_intr", 16'(intr), 16'h0);
        do_iret();
        chk("t2_after_iret", 16'(intr), 16'h0);
        tick();
        chk("t2_intr_b", 16'(intr), 16'h1);
        chk_csr("t2_cause_b", IRQ_CSR_CAUSE, 16'h0005);
        chk_csr("t2_pending_b", IRQ_CSR_PENDING, 16'h0000);
        tick();
        do_iret();
        chk("t2_idle", 16'(in_isr), 16'h0);

        // Masked source stays pending, taken once enabled
        wr(IRQ_CSR_ENABLE, 16'h0000);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_masked_no_intr", 16'(intr), 16'h0);
        end
        chk_csr("t3_pending", IRQ_CSR_PENDING, 16'h0008);
        wr(IRQ_CSR_ENABLE, 16'h0008);
        chk("t3_prewrite_enable", 16'(intr), 16'h0);
        tick();
        chk("t3_intr", 16'(intr), 16'h1);
        chk_csr("t3_cause", IRQ_CSR_CAUSE, 16'h0003);
        tick();
        do_iret();

        // W1C before enabling removes the request
        wr(IRQ_CSR_ENABLE, 16'h0000);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        chk_csr("t3b_pending_set", IRQ_CSR_PENDING, 16'h0008);
        wr(IRQ_CSR_PENDING, 16'h0008);
        chk_csr("t3b_pending_clr", IRQ_CSR_PENDING, 16'h0000);
        wr(IRQ_CSR_ENABLE, 16'h0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3b_no_intr", 16'(intr), 16'h0);
        end

        // iret in ENTER ignored; new rise waits until the real iret
        wr(IRQ_CSR_ENABLE, 16'h00FF);
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick();
        chk("t4_intr", 16'(intr), 16'h1);
        chk_csr("t4_cause", IRQ_CSR_CAUSE, 16'h0001);
        iret    = 1'b1;
        irq_src = 8'h10;
        tick();
        iret    = 1'b0;
        irq_src = 8'h00;
        chk("t4_iret_ignored", 16'(in_isr), 16'h1);
        chk("t4_no_intr0", 16'(intr), 16'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t4_no_intr", 16'(intr), 16'h0);
            chk("t4_in_isr", 16'(in_isr), 16'h1);
        end
        chk_csr("t4_pending", IRQ_CSR_PENDING, 16'h0010);
        do_iret();
        chk("t4_gap", 16'(intr), 16'h0);
        tick();
        chk("t4_intr2", 16'(intr), 16'h1);
        chk_csr("t4_cause2", IRQ_CSR_CAUSE, 16'h0004);
        tick();
        do_iret();

        // Reset mid-ISR with a source pending; line held high across reset
        irq_src = 8'h41;
        tick();
        irq_src = 8'h40;
        tick();
        chk("t5_intr", 16'(intr), 16'h1);
        tick();
        chk("t5_in_isr", 16'(in_isr), 16'h1);
        chk_csr("t5_pending", IRQ_CSR_PENDING, 16'h0040);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_intr", 16'(intr), 16'h0);
        chk("t5_rst_in_isr", 16'(in_isr), 16'h0);
        chk_csr("t5_rst_pending", IRQ_CSR_PENDING, 16'h0000);
        chk_csr("t5_rst_enable", IRQ_CSR_ENABLE, 16'h0000);
        chk_csr("t5_rst_cause", IRQ_CSR_CAUSE, 16'h0000);
        chk_csr("t5_rst_status", IRQ_CSR_STATUS, 16'h0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_post_rst_no_intr", 16'(intr), 16'h0);
        end
        chk_csr("t5_high_at_release", IRQ_CSR_PENDING, 16'h0040);
        wr(IRQ_CSR_ENABLE, 16'h00FF);
        chk("t5_gie_off_a", 16'(intr), 16'h0);
        tick();
        chk("t5_gie_off_b", 16'(intr), 16'h0);
        wr(IRQ_CSR_STATUS, 16'h0001);
        chk("t5_gie_prewrite", 16'(intr), 16'h0);
        tick();
        chk("t5_intr_after_gie", 16'(intr), 16'h1);
        chk_csr("t5_cause", IRQ_CSR_CAUSE, 16'h0006);
        irq_src = 8'h00;
        tick();
        do_iret();
        chk("t5_idle", 16'(in_isr), 16'h0);

        // Set beats W1C on the same bit in the same cycle
        wr(IRQ_CSR_STATUS, 16'h0000);
        csr_we    = 1'b1;
        csr_addr  = IRQ_CSR_PENDING;
        csr_wdata = 16'h0004;
        irq_src   = 8'h04;
        tick();
        csr_we    = 1'b0;
        irq_src   = 8'h00;
        chk_csr("t6_set_wins", IRQ_CSR_PENDING, 16'h0004);
        chk("t6_no_intr", 16'(intr), 16'h0);
        wr(IRQ_CSR_PENDING, 16'h0004);
        chk_csr("t6_w1c", IRQ_CSR_PENDING, 16'h0000);

        // Register field widths and read-only fields
        wr(IRQ_CSR_CAUSE, 16'h000F);
        chk_csr("t7_cause_ro", IRQ_CSR_CAUSE, 16'h0006);
        wr(IRQ_CSR_ENABLE, 16'hFFFF);
        chk_csr("t7_enable_width", IRQ_CSR_ENABLE, 16'h00FF);
        wr(IRQ_CSR_STATUS, 16'hFFFF);
        chk_csr("t7_status_bits", IRQ_CSR_STATUS, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
